sme_feeder: RTL
===============

# sme_feeder

Upstream loader for the string-matching engine (SME). It accepts a newline-delimited byte stream over a valid/ready handshake and buffers one job: a string line followed by a pattern line. It then replays the job into the SME as a contiguous `isstring` burst followed immediately by an `ispattern` burst. It holds off the next job until the SME pulses `valid`.

## Interface

Parameters:
- `STR_MAX`, 32: maximum string characters per job.
- `PAT_MAX`, 8: maximum pattern characters per job.
- `TERM`, 8'h0A: line terminator byte.

Ports:
- `clk`, in, 1: clock, rising edge.
- `reset`, in, 1: reset, asynchronous, active-high.
- `in_data`, in, 8: stream byte.
- `in_valid`, in, 1: `in_data` valid.
- `in_ready`, out, 1: feeder accepts a byte. A transfer occurs when `in_valid & in_ready` at a rising edge.
- `chardata`, out, 8: character to SME, registered.
- `isstring`, out, 1: `chardata` is a string character, registered.
- `ispattern`, out, 1: `chardata` is a pattern character, registered.
- `sme_valid`, in, 1: SME result-valid pulse.
- `err`, out, 1: one-cycle pulse when a job is dropped, registered.
- `busy`, out, 1: job in flight (`TX_STR`, `TX_PAT`, `WAIT`).

## Operation

- **Buffers:**
  - `str_buf[STR_MAX]` with `str_len` (6 bit, 0..32).
  - `pat_buf[PAT_MAX]` with `pat_len` (4 bit, 0..8).
  - Sticky `ovf` flag.
- **States:** `RX_STR`, `RX_PAT`, `TX_STR`, `TX_PAT`, `WAIT`.
- **`in_ready`:** equals 1 only in `RX_STR` and `RX_PAT`. It is a combinational decode of state.
- **`RX_STR`:**
  - Non-`TERM` byte: if `str_len<STR_MAX`, store at `str_buf[str_len]` and increment. Otherwise set `ovf` and discard the byte.
  - `TERM` byte: go to `RX_PAT`.
- **`RX_PAT`:**
  - Non-`TERM` byte: handled the same way against `PAT_MAX`.
  - `TERM` byte with `pat_len==0` or `ovf`: pulse `err`, clear lengths and `ovf`, return to `RX_STR`.
  - `TERM` byte with `str_len==0`: see Configuration.
  - Otherwise: go to `TX_STR`.
- **`TX_STR`:** each cycle, drive `isstring=1` and `chardata=str_buf[idx]`, incrementing `idx`. After `str_len` characters, go to `TX_PAT` with no gap cycle. This is mandatory, because an idle cycle between bursts triggers an SME compare.
- **`TX_PAT`:** drive `ispattern=1` and `chardata=pat_buf[idx]` for `pat_len` cycles, then go to `WAIT`.
- **`WAIT`:**
  - `isstring`, `ispattern` and `chardata` are 0.
  - On `sme_valid=1`: clear lengths and `idx`, go to `RX_STR`.
  - `sme_valid` seen in any other state is ignored.
- Bytes are forwarded untouched. Pattern metacharacters (`^ $ . *`) are not interpreted.

## Timing

- Reset values:
  - `chardata=0`, `isstring=0`, `ispattern=0`, `err=0`, `busy=0`.
  - State `RX_STR`, so `in_ready=1`.
  - `str_len=pat_len=idx=0`, `ovf=0`.
  - Buffer contents are don't-care.
- Pattern `TERM` accepted at edge E: state becomes `TX_STR`. The first `isstring=1` is visible after edge E+1, so there is one bubble cycle.
- The string burst is exactly `str_len` cycles. The pattern burst follows immediately and is exactly `pat_len` cycles. After the last pattern character, outputs are 0 on the next cycle.
- `err` is visible after the edge following the offending `TERM`, and lasts exactly one cycle.
- `in_valid` held high during `TX_STR`/`TX_PAT`/`WAIT` is not accepted. `in_data` must remain stable; the byte transfers in the first `RX_STR` cycle.
- A byte is accepted in the cycle after `sme_valid` (`RX_STR` entry).
- Reset mid-job (any state): all outputs drop on assertion and the job is lost. No partial burst resumes.

## Configuration

Macro `SME_FEEDER_STR_REUSE_EN`:
- **Defined:** a job with `str_len==0` (empty string line) is valid. `TX_STR` is skipped and the feeder goes from `RX_PAT` to `TX_PAT`. This relies on the SME retaining the previous string, so the pattern is matched against it.
- **Undefined:** an empty string line causes an `err` pulse at the pattern `TERM`, and the job is dropped.

## Test plan

- **Basic job:** stream "ab cd\n^c*\n".
  - `isstring` for 5 cycles: `chardata` 61,62,20,63,64.
  - Then `ispattern` for 3 cycles: 5E,63,2A, with no gap.
  - Then idle, `busy=1`, `in_ready=0` until `sme_valid`, then `in_ready=1`.
- **Backpressure:** hold `in_valid=1`, `in_data=0x78` during `WAIT`.
  - The byte is not accepted until the cycle after the `sme_valid` pulse.
  - It becomes `str_buf[0]`.
- **String overflow:** 33-char string plus pattern "a\n".
  - One `err` pulse after the pattern `TERM`.
  - `isstring` and `ispattern` never assert.
  - Back in `RX_STR` with `str_len=0`.
- **Empty pattern:** "abc\n\n" gives one `err` pulse and no bursts.
- **Empty string line:** "\n.b\n".
  - With `SME_FEEDER_STR_REUSE_EN`: no `isstring`; `ispattern` for 2 cycles, 2E,62.
  - Without it: `err` pulse and no bursts.
- **Reset mid-burst:** assert `reset` during the 2nd `ispattern` cycle.
  - `ispattern=0`, `busy=0`, `in_ready=1` immediately.
  - A following fresh job replays correctly.

Source files
------------

// File: rtl/sme_feeder.sv
// Buffers one newline-delimited job (string line, then pattern line) and replays it into the SME.
// Optional macro SME_FEEDER_STR_REUSE_EN lets an empty string line reuse the SME's previous string.
module sme_feeder #(
    parameter int          STR_MAX = 32,
    parameter int          PAT_MAX = 8,
    parameter logic [7:0]  TERM    = 8'h0A
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] chardata,
    output logic       isstring,
    output logic       ispattern,
    input  logic       sme_valid,
    output logic       err,
    output logic       busy
);

    localparam int STR_LW = $clog2(STR_MAX + 1);
    localparam int PAT_LW = $clog2(PAT_MAX + 1);
    localparam int STR_AW = $clog2(STR_MAX);
    localparam int PAT_AW = $clog2(PAT_MAX);
    localparam int IDX_W  = (STR_LW > PAT_LW) ? STR_LW : PAT_LW;
    localparam logic [STR_LW-1:0] STR_FULL = STR_LW'(STR_MAX);
    localparam logic [PAT_LW-1:0] PAT_FULL = PAT_LW'(PAT_MAX);

`ifdef SME_FEEDER_STR_REUSE_EN
    localparam bit STR_REUSE = 1'b1;
`else
    localparam bit STR_REUSE = 1'b0;
`endif

    typedef enum logic [2:0] {RX_STR, RX_PAT, TX_STR, TX_PAT, WAIT} state_t;

    state_t            state, state_next;
    logic [7:0]        str_buf [STR_MAX];
    logic [7:0]        pat_buf [PAT_MAX];
    logic [STR_LW-1:0] str_len;
    logic [PAT_LW-1:0] pat_len;
    logic [IDX_W-1:0]  idx;
    logic              ovf;

    logic       accept, is_term, bad_job, str_room, pat_room, str_last, pat_last;
    logic [7:0] chardata_d;
    logic       isstring_d, ispattern_d;

    assign accept   = in_valid & in_ready;
    assign is_term  = (in_data == TERM);
    assign str_room = (str_len < STR_FULL);
    assign pat_room = (pat_len < PAT_FULL);
    assign str_last = (idx == IDX_W'(str_len - 1'b1));
    assign pat_last = (idx == IDX_W'(pat_len - 1'b1));
    assign bad_job  = (state == RX_PAT) && accept && is_term &&
                      ((pat_len == '0) || ovf || (!STR_REUSE && (str_len == '0)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RX_STR;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            RX_STR: if (accept && is_term) state_next = RX_PAT;
            RX_PAT: begin
                if (accept && is_term) begin
                    if (bad_job)              state_next = RX_STR;
                    else if (str_len == '0)   state_next = TX_PAT;
                    else                      state_next = TX_STR;
                end
            end
            // The pattern burst must follow the string burst with no idle cycle.
            TX_STR: if (str_last) state_next = TX_PAT;
            TX_PAT: if (pat_last) state_next = WAIT;
            WAIT:   if (sme_valid) state_next = RX_STR;
            default: state_next = RX_STR;
        endcase
    end

    always_comb begin
        in_ready    = (state == RX_STR) || (state == RX_PAT);
        busy        = (state == TX_STR) || (state == TX_PAT) || (state == WAIT);
        chardata_d  = 8'h00;
        isstring_d  = 1'b0;
        ispattern_d = 1'b0;
        if (state == TX_STR) begin
            chardata_d = str_buf[idx[STR_AW-1:0]];
            isstring_d = 1'b1;
        end else if (state == TX_PAT) begin
            chardata_d  = pat_buf[idx[PAT_AW-1:0]];
            ispattern_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !is_term) begin
            if (state == RX_STR && str_room) str_buf[str_len[STR_AW-1:0]] <= in_data;
            if (state == RX_PAT && pat_room) pat_buf[pat_len[PAT_AW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            str_len <= '0;
            pat_len <= '0;
            idx     <= '0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                RX_STR: begin
                    if (accept && !is_term) begin
                        if (str_room) str_len <= str_len + 1'b1;
                        else          ovf     <= 1'b1;
                    end
                end
                RX_PAT: begin
                    if (accept && !is_term) begin
                        if (pat_room) pat_len <= pat_len + 1'b1;
                        else          ovf     <= 1'b1;
                    end else if (bad_job) begin
                        str_len <= '0;
                        pat_len <= '0;
                        ovf     <= 1'b0;
                    end
                end
                TX_STR: idx <= str_last ? '0 : idx + 1'b1;
                TX_PAT: idx <= pat_last ? '0 : idx + 1'b1;
                WAIT: begin
                    if (sme_valid) begin
                        str_len <= '0;
                        pat_len <= '0;
                        idx     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chardata  <= 8'h00;
            isstring  <= 1'b0;
            ispattern <= 1'b0;
            err       <= 1'b0;
        end else begin
            chardata  <= chardata_d;
            isstring  <= isstring_d;
            ispattern <= ispattern_d;
            err       <= bad_job;
        end
    end

endmodule
